// File: rtl/kmul_pkg.sv
// Shared definitions for the pipelined Karatsuba multiplier kmul_pipe.
// With KMUL_TAG_EN defined, the sideband struct also carries the transaction tag.
package kmul_pkg;

`ifdef KMUL_TAG_EN
    localparam int KMUL_TAG_MAX = 32;
`endif

    // Operand width must be even and at least 8; H is the half-word width.
    function automatic int kmul_half(input int wid);
        return wid / 2;
    endfunction

    function automatic int kmul_lat(input int sub_dep);
        return sub_dep + 6;
    endfunction

    typedef struct packed {
        logic valid;
        logic rs;
        logic s3;
`ifdef KMUL_TAG_EN
        logic [KMUL_TAG_MAX-1:0] tag;
`endif
    } kmul_sb_t;

endpackage

// File: rtl/kmul_pipe_sub_mult.sv
// Unsigned HxH multiply followed by a SUB_DEP-deep ce-gated register chain.
// No reset: the chain only carries data, validity travels in the parent's sideband.
module kmul_sub_mult
    import kmul_pkg::*;
#(
    parameter int H       = 44,
    parameter int SUB_DEP = 11
) (
    input  logic           clk,
    input  logic           ce,
    input  logic [H-1:0]   x,
    input  logic [H-1:0]   y,
    output logic [2*H-1:0] p
);
    logic [2*H-1:0] pipe_q [SUB_DEP];
    logic [2*H-1:0] pipe_d [SUB_DEP];

    // Product enters the chain combinationally so synthesis can retime it across the stages.
    always_comb begin
        pipe_d[0] = (2*H)'(x) * (2*H)'(y);
        for (int k = 1; k < SUB_DEP; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            for (int k = 0; k < SUB_DEP; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    assign p = pipe_q[SUB_DEP-1];

endmodule

// File: rtl/kmul_pipe.sv
// Fully pipelined signed/unsigned Karatsuba multiplier, latency SUB_DEP+6 ce-cycles.
// Optional macro KMUL_TAG_EN carries tag_i alongside each transaction to tag_o.
module kmul_pipe
    import kmul_pkg::*;
#(
    parameter int WID     = 88,
    parameter int SUB_DEP = 11,
    parameter int TAG_WID = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               in_valid,
    input  logic               sgn,
    input  logic [WID-1:0]     a,
    input  logic [WID-1:0]     b,
    input  logic [TAG_WID-1:0] tag_i,
    output logic               out_valid,
    output logic [2*WID-1:0]   o,
    output logic [TAG_WID-1:0] tag_o
);
    localparam int H   = kmul_half(WID);
    localparam int LAT = kmul_lat(SUB_DEP);
    localparam int PW  = 2 * WID;

    kmul_sb_t sb_q [1:LAT];
    kmul_sb_t sb_d [1:LAT];

    logic [WID-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic [H:0]     da_q, da_d, db_q, db_d, neg_da, neg_db;
    logic [H-1:0]   ah2_q, ah2_d, al2_q, al2_d, bh2_q, bh2_d, bl2_q, bl2_d;
    logic [H-1:0]   mda_q, mda_d, mdb_q, mdb_d;
    logic [H-1:0]   ah3_q, ah3_d, al3_q, al3_d, bh3_q, bh3_d, bl3_q, bl3_d;
    logic [2*H-1:0] z2_m, z0_m, p3_m;
    logic [2*H:0]   p3_ext, p4_q, p4_d;
    logic [2*H-1:0] z2_4_q, z2_4_d, z0_4_q, z0_4_d;
    logic [2*H+1:0] z1_q, z1_d;
    logic [2*H-1:0] z2_5_q, z2_5_d, z0_5_q, z0_5_d;
    logic [PW-1:0]  m_sum, o_q, o_d;

    always_comb begin
        sb_d[1]       = '0;
        sb_d[1].valid = in_valid;
        sb_d[1].rs    = sgn & (a[WID-1] ^ b[WID-1]);
`ifdef KMUL_TAG_EN
        sb_d[1].tag   = KMUL_TAG_MAX'(tag_i);
`endif
        for (int k = 2; k <= LAT; k++) begin
            sb_d[k] = sb_q[k-1];
        end
        sb_d[3].s3 = da_q[H] ^ db_q[H];
    end

    always_comb begin
        mag_a_d = (sgn && a[WID-1]) ? -a : a;
        mag_b_d = (sgn && b[WID-1]) ? -b : b;

        // d_a = lo - hi but d_b = hi - lo, so the corrected middle term is z2 + z0 + d_a*d_b.
        da_d  = {1'b0, mag_a_q[H-1:0]} - {1'b0, mag_a_q[WID-1:H]};
        db_d  = {1'b0, mag_b_q[WID-1:H]} - {1'b0, mag_b_q[H-1:0]};
        ah2_d = mag_a_q[WID-1:H];
        al2_d = mag_a_q[H-1:0];
        bh2_d = mag_b_q[WID-1:H];
        bl2_d = mag_b_q[H-1:0];

        neg_da = -da_q;
        neg_db = -db_q;
        mda_d  = da_q[H] ? neg_da[H-1:0] : da_q[H-1:0];
        mdb_d  = db_q[H] ? neg_db[H-1:0] : db_q[H-1:0];
        ah3_d  = ah2_q;
        al3_d  = al2_q;
        bh3_d  = bh2_q;
        bl3_d  = bl2_q;

        p3_ext = {1'b0, p3_m};
        p4_d   = sb_q[3+SUB_DEP].s3 ? -p3_ext : p3_ext;
        z2_4_d = z2_m;
        z0_4_d = z0_m;

        z1_d   = {p4_q[2*H], p4_q} + {2'b00, z2_4_q} + {2'b00, z0_4_q};
        z2_5_d = z2_4_q;
        z0_5_d = z0_4_q;

        m_sum = {z2_5_q, z0_5_q} + (PW'(z1_q) << H);
        o_d   = o_q;
        if (sb_q[LAT-1].valid) begin
            o_d = sb_q[LAT-1].rs ? -m_sum : m_sum;
        end
    end

    kmul_sub_mult #(.H(H), .SUB_DEP(SUB_DEP)) u_mul_hi (
        .clk (clk), .ce (ce), .x (ah3_q), .y (bh3_q), .p (z2_m)
    );

    kmul_sub_mult #(.H(H), .SUB_DEP(SUB_DEP)) u_mul_lo (
        .clk (clk), .ce (ce), .x (al3_q), .y (bl3_q), .p (z0_m)
    );

    kmul_sub_mult #(.H(H), .SUB_DEP(SUB_DEP)) u_mul_mid (
        .clk (clk), .ce (ce), .x (mda_q), .y (mdb_q), .p (p3_m)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 1; k <= LAT; k++) begin
                sb_q[k] <= '0;
            end
            o_q <= '0;
        end else if (ce) begin
            for (int k = 1; k <= LAT; k++) begin
                sb_q[k] <= sb_d[k];
            end
            o_q <= o_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            da_q    <= da_d;
            db_q    <= db_d;
            ah2_q   <= ah2_d;
            al2_q   <= al2_d;
            bh2_q   <= bh2_d;
            bl2_q   <= bl2_d;
            mda_q   <= mda_d;
            mdb_q   <= mdb_d;
            ah3_q   <= ah3_d;
            al3_q   <= al3_d;
            bh3_q   <= bh3_d;
            bl3_q   <= bl3_d;
            p4_q    <= p4_d;
            z2_4_q  <= z2_4_d;
            z0_4_q  <= z0_4_d;
            z1_q    <= z1_d;
            z2_5_q  <= z2_5_d;
            z0_5_q  <= z0_5_d;
        end
    end

    assign out_valid = sb_q[LAT].valid;
    assign o         = o_q;

`ifdef KMUL_TAG_EN
    assign tag_o = sb_q[LAT].tag[TAG_WID-1:0];
`else
    logic unused_tag;
    assign unused_tag = ^tag_i;
    assign tag_o      = '0;
`endif

endmodule
